// File: rtl/sm_pkg.sv
// Shared definitions for the S-Machine fetch path: default widths, reset PC and fetch FSM states.
package sm_pkg;

    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_INST_W     = 16;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_RESET_PC   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    // Occupancy counter width for a FIFO of the given depth (must reach DEPTH itself).
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sm_sync_fifo.sv
// Small synchronous FIFO with show-ahead head, flush and occupancy count.
// Depth must be a power of two so the pointers wrap naturally.
module sm_sync_fifo
    import sm_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    input  logic                        flush,
    output logic [WIDTH-1:0]            pop_data,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == CNT_W'(0));
    assign pop_data  = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Pointer and occupancy bookkeeping; flush empties the queue without touching storage.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count    <= CNT_W'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count <= count + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
    end

    // Entry storage; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: prefetches 16-bit instructions over a single-outstanding
// req/ack memory port into a small FIFO and issues them to the CPU as inst + enable strobe.
// Redirect discards buffered and in-flight fetches and restarts at redirect_pc.
module inst_fetch_unit
    import sm_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter int                INST_W     = DEF_INST_W,
    parameter int                FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              hold,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst,
    output logic              enable,
    output logic [ADDR_W-1:0] issue_pc
);

    localparam int              CNT_W   = cnt_width(FIFO_DEPTH);
    localparam int              ENT_W   = INST_W + ADDR_W;
    localparam logic [CNT_W:0]  DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);

    fetch_state_t       state_r;
    logic [ADDR_W-1:0]  fetch_ptr_r;
    logic [ADDR_W-1:0]  ptr_inc_s;
    logic               push_s;
    logic               pop_s;
    logic               space_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [CNT_W-1:0]   fifo_count_s;
    logic [CNT_W:0]     count_after_s;
    logic [ENT_W-1:0]   push_data_s;
    logic [ENT_W-1:0]   head_s;

    assign push_data_s = {imem_rdata, imem_addr};

    sm_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .flush     (redirect),
        .pop_data  (head_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // FIFO control and space check; space looks at occupancy after this cycle's push/pop,
    // since a request started now will land on top of that.
    always_comb begin
        pop_s = run && !hold && !redirect && !fifo_empty_s;
        if ((state_r == REQ) && imem_ack && !redirect) begin
            push_s = !fifo_full_s || pop_s;
        end else begin
            push_s = 1'b0;
        end
        count_after_s = (CNT_W + 1)'(fifo_count_s) + (CNT_W + 1)'(push_s) - (CNT_W + 1)'(pop_s);
        space_s       = (count_after_s < DEPTH_V);
        ptr_inc_s     = fetch_ptr_r + ADDR_W'(1);
    end

    // Fetch FSM: owns the memory request, its address and the next fetch pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            fetch_ptr_r <= RESET_PC;
        end else begin
            case (state_r)
                IDLE: begin
                    if (redirect) begin
                        fetch_ptr_r <= redirect_pc;
                    end else if (run && space_s) begin
                        state_r   <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_ptr_r;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        fetch_ptr_r <= redirect_pc;
                        if (imem_ack) begin
                            // Data arriving with the redirect belongs to the old stream.
                            state_r  <= IDLE;
                            imem_req <= 1'b0;
                        end else begin
                            // Request must stay up until memory completes it.
                            state_r <= FLUSH;
                        end
                    end else if (imem_ack) begin
                        fetch_ptr_r <= ptr_inc_s;
                        if (run && space_s) begin
                            imem_addr <= ptr_inc_s;
                        end else begin
                            state_r  <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end else begin
                        state_r <= REQ;
                    end
                end
                FLUSH: begin
                    if (redirect) begin
                        fetch_ptr_r <= redirect_pc;
                    end
                    if (imem_ack) begin
                        state_r  <= IDLE;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // Issue register: one strobe per popped entry; inst and issue_pc hold between issues.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst     <= '0;
            issue_pc <= '0;
            enable   <= 1'b0;
        end else if (pop_s) begin
            inst     <= head_s[ENT_W-1:ADDR_W];
            issue_pc <= head_s[ADDR_W-1:0];
            enable   <= 1'b1;
        end else begin
            enable <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: a memory model answers mem[a] = 16'h2000 | a,
// directed tests push expected issues into a queue, and a monitor pops/compares on enable.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        hold = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] inst;
    logic        enable;
    logic [7:0]  issue_pc;

    int total = 0;
    int bad = 0;
    logic [23:0] sb[$];
    logic [7:0]  req_log[$];
    int mem_lat = 0;
    int ack_cnt = 0;
    int n_issued = 0;
    int run_len = 0;
    int max_run = 0;
    int en_in_hold = 0;
    bit hold_phase = 1'b0;
    int cyc = 0;
    int first_ack_cyc = -1;
    int first_en_cyc = -1;

    inst_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .hold        (hold),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .enable      (enable),
        .issue_pc    (issue_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] exp_word(input logic [7:0] a);
        return {8'h20, a, a};
    endfunction

    function automatic logic [7:0] log_at(input int i);
        if (i < req_log.size()) return req_log[i];
        return 8'hxx;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_issued(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (n_issued < target && k < budget) begin
            step(1);
            k++;
        end
        check(name, n_issued, target);
    endtask

    // Memory model: acks a pending request after mem_lat idle cycles, one cycle of ack per request.
    initial begin : mem_model
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end else if (imem_ack) begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end else if (imem_req) begin
                if (wait_cnt >= mem_lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = {8'h20, imem_addr};
                    wait_cnt   = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: logs new requests, checks address stability, pops the scoreboard on enable.
    initial begin : monitor
        bit          prev_req;
        bit          prev_ack;
        logic [7:0]  cur_addr;
        logic [23:0] e;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        cur_addr = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                prev_req = 1'b0;
                prev_ack = 1'b0;
                run_len  = 0;
            end else begin
                if (imem_req && (!prev_req || prev_ack)) begin
                    req_log.push_back(imem_addr);
                    cur_addr = imem_addr;
                end else if (imem_req) begin
                    check("addr_stable", imem_addr, cur_addr);
                end
                if (imem_req && imem_ack) begin
                    ack_cnt++;
                    if (first_ack_cyc < 0) first_ack_cyc = cyc;
                end
                if (enable) begin
                    if (first_en_cyc < 0) first_en_cyc = cyc;
                    n_issued++;
                    run_len++;
                    if (run_len > max_run) max_run = run_len;
                    if (hold_phase) en_in_hold++;
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_issue: got inst=%h pc=%h expected no issue", inst, issue_pc);
                    end else begin
                        e = sb.pop_front();
                        check("issue", {8'h00, inst, issue_pc}, {8'h00, e});
                    end
                end else begin
                    run_len = 0;
                end
                prev_req = imem_req;
                prev_ack = imem_ack;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int         base;
        int         k;
        logic [7:0] a;

        // Reset state
        step(3);
        check("reset_req", imem_req, 0);
        check("reset_addr", imem_addr, 8'h00);
        check("reset_inst", inst, 16'h0000);
        check("reset_enable", enable, 0);
        check("reset_issue_pc", issue_pc, 8'h00);
        reset = 1'b0;

        // T1: continuous fetch from RESET_PC, first-issue latency
        first_ack_cyc = -1;
        first_en_cyc  = -1;
        for (int i = 0; i < 8; i++) sb.push_back(exp_word(8'(i)));
        run = 1'b1;
        wait_issued(8, 100, "t1_issue_count");
        hold = 1'b1;
        check("t1_latency", first_en_cyc - first_ack_cyc, 2);
        check("t1_sb_drained", sb.size(), 0);
        step(12);

        // T2: hold after first issue buffers exactly four, then burst on release
        for (int i = 0; i < 8; i++) sb.push_back(exp_word(8'(8'h10 + i)));
        req_log.delete();
        redirect = 1'b1;
        redirect_pc = 8'h10;
        step(1);
        redirect = 1'b0;
        hold = 1'b0;
        base = n_issued;
        wait_issued(base + 1, 50, "t2_first_issue");
        hold = 1'b1;
        hold_phase = 1'b1;
        en_in_hold = 0;
        step(10);
        check("t2_req_idle", imem_req, 0);
        check("t2_no_issue_in_hold", en_in_hold, 0);
        check("t2_requests", req_log.size(), 5);
        hold_phase = 1'b0;
        max_run = 0;
        hold = 1'b0;
        wait_issued(base + 8, 100, "t2_issue_count");
        hold = 1'b1;
        check("t2_burst", (max_run >= 4), 1);
        check("t2_sb_drained", sb.size(), 0);
        step(12);

        // T3: redirect while request to 05 pending with slow memory
        mem_lat = 3;
        redirect = 1'b1;
        redirect_pc = 8'h05;
        step(1);
        redirect = 1'b0;
        k = 0;
        while (!(imem_req && imem_addr == 8'h05) && k < 40) begin
            step(1);
            k++;
        end
        check("t3_req05_seen", {imem_req, imem_addr}, {1'b1, 8'h05});
        for (int i = 0; i < 4; i++) sb.push_back(exp_word(8'(8'h40 + i)));
        req_log.delete();
        redirect = 1'b1;
        redirect_pc = 8'h40;
        hold = 1'b0;
        step(1);
        redirect = 1'b0;
        check("t3_addr_held", {imem_req, imem_addr}, {1'b1, 8'h05});
        base = n_issued;
        wait_issued(base + 4, 200, "t3_issue_count");
        hold = 1'b1;
        mem_lat = 0;
        check("t3_next_req", log_at(0), 8'h40);
        check("t3_sb_drained", sb.size(), 0);
        step(12);

        // T4: redirect coincident with ack; buffered and acked words dropped
        redirect = 1'b1;
        redirect_pc = 8'h70;
        step(1);
        redirect = 1'b0;
        k = 0;
        while (!(imem_ack && imem_addr == 8'h71) && k < 30) begin
            step(1);
            k++;
        end
        check("t4_ack71_seen", {imem_ack, imem_addr}, {1'b1, 8'h71});
        for (int i = 0; i < 4; i++) sb.push_back(exp_word(8'(8'h80 + i)));
        req_log.delete();
        redirect = 1'b1;
        redirect_pc = 8'h80;
        hold = 1'b0;
        step(1);
        redirect = 1'b0;
        check("t4_enable_after_redirect", enable, 0);
        base = n_issued;
        wait_issued(base + 4, 100, "t4_issue_count");
        hold = 1'b1;
        check("t4_next_req", log_at(0), 8'h80);
        check("t4_sb_drained", sb.size(), 0);
        step(12);

        // T5: address wrap FE -> 01
        a = 8'hFE;
        repeat (4) begin
            sb.push_back(exp_word(a));
            a = a + 8'd1;
        end
        req_log.delete();
        redirect = 1'b1;
        redirect_pc = 8'hFE;
        hold = 1'b0;
        step(1);
        redirect = 1'b0;
        base = n_issued;
        wait_issued(base + 4, 100, "t5_issue_count");
        hold = 1'b1;
        check("t5_req0", log_at(0), 8'hFE);
        check("t5_req1", log_at(1), 8'hFF);
        check("t5_req2", log_at(2), 8'h00);
        check("t5_req3", log_at(3), 8'h01);
        check("t5_sb_drained", sb.size(), 0);
        step(12);

        // T6: reset mid-request with two buffered
        mem_lat = 2;
        redirect = 1'b1;
        redirect_pc = 8'h20;
        step(1);
        redirect = 1'b0;
        base = ack_cnt;
        k = 0;
        while (!((ack_cnt - base) >= 2 && imem_req && !imem_ack) && k < 40) begin
            step(1);
            k++;
        end
        check("t6_two_buffered", {(ack_cnt - base >= 2), imem_req, imem_ack}, 3'b110);
        reset = 1'b1;
        step(1);
        check("t6_req", imem_req, 0);
        check("t6_enable", enable, 0);
        check("t6_inst", inst, 16'h0000);
        check("t6_issue_pc", issue_pc, 8'h00);
        check("t6_addr", imem_addr, 8'h00);
        mem_lat = 0;
        for (int i = 0; i < 4; i++) sb.push_back(exp_word(8'(i)));
        req_log.delete();
        reset = 1'b0;
        hold = 1'b0;
        base = n_issued;
        wait_issued(base + 4, 100, "t6_issue_count");
        hold = 1'b1;
        check("t6_refetch", log_at(0), 8'h00);
        check("t6_sb_drained", sb.size(), 0);
        step(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
